imem_loader: RTL and testbench

- Boot-time writer for the instruction memory: receives a framed byte stream, assembles big-endian 32-bit MIPS instructions, and writes them word by word into the writable instruction memory.
- The CPU fetch side reads that memory with byte addresses; instruction word N is at byte address 4·N, and the fetch side ignores adr[1:0].
- Holds the CPU in reset until a complete, checksum-verified program is loaded.
- Sits between the byte source (UART receiver or testbench) and the instruction RAM write port.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_ram.sv | 50 +++++
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory boot loader:
//   - HDR_W       : width of the frame word-count header (two header bytes)
//   - state_t     : loader FSM states
//   - word_to_adr : word index -> byte address used on the RAM write port
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int unsigned HDR_W = 16;

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // Instruction word N lives at byte address 4*N.
    function automatic logic [31:0] word_to_adr(input logic [HDR_W-1:0] idx);
        return {{(30 - HDR_W){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Byte-stream handshake plus instruction-RAM write bus of the boot loader.
//   rx_data/rx_valid/rx_ready : byte source -> loader (accept on valid && ready)
//   mem_we/mem_adr/mem_din    : loader -> instruction RAM write port
// Modports:
//   slave  : the loader's view (consumes bytes, drives the write bus)
//   master : the environment's view (byte source and RAM side)
// -----------------------------------------------------------------------------
interface imem_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_din;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_adr,
        output mem_din
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_adr,
        input  mem_din
    );

endinterface

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// DEPTH x 32 instruction RAM: synchronous single write port, asynchronous
// read port. Both ports are byte-addressed; adr[1:0] is ignored and addresses
// beyond DEPTH words are dropped on write and read back as zero.
// Ports:
//   clk      : write clock
//   mem_we   : write strobe
//   mem_adr  : write byte address
//   mem_din  : write data
//   rd_adr   : fetch byte address
//   rd_data  : fetched instruction word
// Contents are not reset.
// -----------------------------------------------------------------------------
module imem_ram #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        mem_we,
    input  logic [31:0] mem_adr,
    input  logic [31:0] mem_din,
    input  logic [31:0] rd_adr,
    output logic [31:0] rd_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];
    logic        wr_in_range;
    logic        rd_in_range;
    logic        unused_lsbs;

    assign wr_in_range = ({2'b00, mem_adr[31:2]} < DEPTH);
    assign rd_in_range = ({2'b00, rd_adr[31:2]} < DEPTH);
    assign unused_lsbs = ^{mem_adr[1:0], rd_adr[1:0]};

    always_ff @(posedge clk) begin
        if (mem_we && wr_in_range) begin
            mem[mem_adr[AW+1:2]] <= mem_din;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = mem[rd_adr[AW+1:2]];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time instruction memory writer. Receives a framed byte stream
//   count_hi, count_lo, 4*N data bytes (big-endian words), checksum byte
// where checksum = XOR of the data bytes, writes each assembled word to the
// instruction RAM, and releases the CPU from reset only after a complete,
// checksum-verified load.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : byte-stream handshake and RAM write bus (slave modport)
//   cpu_reset  : high while the CPU must stay in reset (low only when done)
//   done       : sticky, load complete and checksum matched
//   error      : sticky, load aborted (oversize header or bad checksum)
// -----------------------------------------------------------------------------
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CNT_W = HDR_W   // header is always two bytes
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [CNT_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [7:0]         chk_q,      chk_d;
    logic [23:0]        asm_q,      asm_d;
    logic               mem_we_q,   mem_we_d;
    logic [31:0]        mem_adr_q,  mem_adr_d;
    logic [31:0]        mem_din_q,  mem_din_d;

    logic               rx_ready;
    logic               accept;
    logic [CNT_W-1:0]   count_full;

    assign rx_ready   = (state_q != DONE) && (state_q != ERR);
    assign accept     = bus.rx_valid && rx_ready;
    // Complete word count as it becomes known on the low header byte.
    assign count_full = {count_q[CNT_W-1:8], bus.rx_data};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        chk_d      = chk_q;
        asm_d      = asm_q;
        mem_we_d   = 1'b0;
        mem_adr_d  = mem_adr_q;
        mem_din_d  = mem_din_q;

        if (accept) begin
            unique case (state_q)
                CNT_HI: begin
                    count_d[CNT_W-1:8] = bus.rx_data;
                    state_d            = CNT_LO;
                end
                CNT_LO: begin
                    count_d = count_full;
                    if (count_full > CNT_W'(DEPTH)) begin
                        state_d = ERR;
                    end else if (count_full == '0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    chk_d      = chk_q ^ bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Only the first three bytes are stored; the fourth is
                        // merged straight into the registered write data.
                        mem_we_d   = 1'b1;
                        mem_adr_d  = word_to_adr(word_idx_q);
                        mem_din_d  = {asm_q, bus.rx_data};
                        word_idx_d = word_idx_q + CNT_W'(1);
                        if (word_idx_q + CNT_W'(1) == count_q) begin
                            state_d = CHK;
                        end
                    end else begin
                        asm_d = {asm_q[15:0], bus.rx_data};
                    end
                end
                CHK: begin
                    state_d = (bus.rx_data == chk_q) ? DONE : ERR;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CNT_HI;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            chk_q      <= '0;
            asm_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            chk_q      <= chk_d;
            asm_q      <= asm_d;
            mem_we_q   <= mem_we_d;
            mem_adr_q  <= mem_adr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_adr  = mem_adr_q;
    assign bus.mem_din  = mem_din_q;
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERR);
    assign cpu_reset    = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader with an imem_ram attached to its write
// bus. The stimulus side builds frames from word lists, predicts every RAM
// write and pushes it into a queue; an independent monitor pops and compares
// each mem_we pulse. Terminal status and RAM contents are compared against a
// word-array model of the memory.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int unsigned DEPTH = 256;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] din;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [31:0] rd_adr;
    logic [31:0] rd_data;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    imem_ram #(.DEPTH(DEPTH)) ram (
        .clk     (clk),
        .mem_we  (bus.mem_we),
        .mem_adr (bus.mem_adr),
        .mem_din (bus.mem_din),
        .rd_adr  (rd_adr),
        .rd_data (rd_data)
    );

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] frame_words[$];
    logic [31:0] last_adr = '0;
    logic [31:0] last_din = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor: scoreboard and output-rule checks -------------
    always @(negedge clk) begin
        if (reset) begin
            last_adr = '0;
            last_din = '0;
        end else begin
            chk("done_and_error_exclusive", 32'(done && error), 32'd0);
            chk("cpu_reset_tracks_done", 32'(cpu_reset), 32'(!done));
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_adr", bus.mem_adr, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("write_adr", bus.mem_adr, w.adr);
                    chk("write_din", bus.mem_din, w.din);
                end
                last_adr = bus.mem_adr;
                last_din = bus.mem_din;
            end else begin
                chk("idle_adr_hold", bus.mem_adr, last_adr);
                chk("idle_din_hold", bus.mem_din, last_din);
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic check_reset_values();
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_adr", bus.mem_adr, 32'd0);
        chk("rst_mem_din", bus.mem_din, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
    endtask

    task automatic apply_reset();
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check_reset_values();
    endtask

    // gap: 0 = back-to-back, 1 = idle cycle after every byte, 2 = random idles
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n_idle;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        n_idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (n_idle) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Streams a frame of header n and the words in frame_words. abort_after>=0
    // applies reset after that many data bytes and returns.
    task automatic send_frame(input logic [15:0] n, input bit bad,
                              input int gap, input int abort_after);
        logic [7:0]  cs;
        logic [31:0] w;
        bit          legal;
        bit          exp_done;
        int          sent;
        cs    = 8'h00;
        sent  = 0;
        legal = (n <= DEPTH);
        for (int i = 0; i < int'(n) && i < frame_words.size(); i++) begin
            w  = frame_words[i];
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        if (legal) begin
            for (int i = 0; i < int'(n); i++) begin
                w = frame_words[i];
                for (int b = 0; b < 4; b++) begin
                    if (abort_after >= 0 && sent == abort_after) begin
                        apply_reset();
                        chk("abort_no_pending_writes", 32'(exp_q.size()), 32'd0);
                        return;
                    end
                    if (b == 3) begin
                        exp_q.push_back('{adr: 32'(i) * 4, din: w});
                        exp_mem[i] = w;
                    end
                    send_byte(w[31 - 8*b -: 8], gap);
                    sent++;
                end
            end
            send_byte(bad ? (cs ^ 8'h01) : cs, gap);
        end
        exp_done = legal && !bad;
        chk("end_done", 32'(done), 32'(exp_done));
        chk("end_error", 32'(error), 32'(!exp_done));
        chk("end_cpu_reset", 32'(cpu_reset), 32'(!exp_done));
        chk("end_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("end_writes_all_seen", 32'(exp_q.size()), 32'd0);
        // Terminal states ignore further input.
        for (int k = 0; k < 6; k++) send_byte(8'($urandom), 0);
        chk("sticky_done", 32'(done), 32'(exp_done));
        chk("sticky_error", 32'(error), 32'(!exp_done));
    endtask

    task automatic check_mem(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            rd_adr = 32'(i) * 4 + 32'($urandom_range(0, 3));
            #1;
            chk($sformatf("ram_word_%0d", i), rd_data, exp_mem[i]);
        end
    endtask

    // ---------------- test sequence -----------------------------------------
    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rd_adr       = '0;
        for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = 'x;

        apply_reset();

        // Nominal two-word load, 1 byte/cycle.
        frame_words = '{32'h2008_0005, 32'h8C09_0000};
        send_frame(16'd2, 1'b0, 0, -1);
        check_mem(0, 1);

        // Same frame with a corrupted checksum: writes still happen.
        apply_reset();
        frame_words = '{32'h2008_0005, 32'h8C09_0000};
        send_frame(16'd2, 1'b1, 0, -1);

        // Oversize header (257 words).
        apply_reset();
        send_frame(16'h0101, 1'b0, 0, -1);

        // Empty program, good then bad checksum.
        apply_reset();
        send_frame(16'd0, 1'b0, 0, -1);
        apply_reset();
        send_frame(16'd0, 1'b1, 0, -1);

        // Throttled input, then a reset after two data bytes, then a 1-word frame.
        apply_reset();
        frame_words = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_00A5};
        send_frame(16'd3, 1'b0, 1, -1);
        apply_reset();
        frame_words = '{32'hCAFE_F00D, 32'h0BAD_0BAD};
        send_frame(16'd2, 1'b0, 1, 2);
        frame_words = '{32'h240A_0007};
        send_frame(16'd1, 1'b0, 0, -1);
        check_mem(0, 2);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            int n;
            apply_reset();
            n = int'($urandom_range(1, 8));
            frame_words.delete();
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            send_frame(16'(n), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), -1);
        end
        apply_reset();
        send_frame(16'($urandom_range(DEPTH + 1, 16'hFFFF)), 1'b0, 0, -1);

        // Full-depth load: word i = i.
        apply_reset();
        frame_words.delete();
        for (int i = 0; i < int'(DEPTH); i++) frame_words.push_back(32'(i));
        send_frame(16'(DEPTH), 1'b0, 0, -1);
        chk("full_depth_last_adr", last_adr, 32'h0000_03FC);
        chk("full_depth_last_din", last_din, 32'h0000_00FF);
        check_mem(0, int'(DEPTH) - 1);

        // Full depth with a bad checksum, random throttling.
        apply_reset();
        frame_words.delete();
        for (int i = 0; i < int'(DEPTH); i++) frame_words.push_back($urandom);
        send_frame(16'(DEPTH), 1'b1, 2, -1);
        check_mem(0, int'(DEPTH) - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
